text_write_arbiter: RTL and testbench
=====================================

# text_write_arbiter

Shares the single write port of the text engine's character buffer between two independent requesters (for example a UART receiver and a status updater) and a bulk clear sequencer. It sits between those requesters and the text buffer behind the SSD1306 LCD path, in the same 1 MHz divided clock domain as the LCD driver and text engine. It performs round-robin arbitration of single-character writes and autonomously fills the whole buffer on a clear command.

## Interface
- CHAR_COUNT, 64: number of character cells (4 rows × 16 columns).
- ADDR_WIDTH, 6: character address width; CHAR_COUNT ≤ 2^ADDR_WIDTH.
- FILL_CHAR, 8'h20: code written to every cell during a clear.

Ports:
- i_clk  in  1  clock, the divided LCD clock; single clock domain.
- i_rst  in  1  reset, synchronous, active-high.
- i_a_req  in  1  requester A write request; level, held until ack.
- i_a_addr  in  ADDR_WIDTH  requester A cell address.
- i_a_char  in  8  requester A character code.
- o_a_ack  out  1  one-cycle pulse: A's write issued.
- i_b_req, i_b_addr, i_b_char, o_b_ack: same as A, for requester B.
- i_clear  in  1  clear command; single-cycle pulse or level.
- o_clear_done  out  1  one-cycle pulse after the last fill write.
- o_busy  out  1  high while a clear is pending or running.
- o_we  out  1  text buffer write enable.
- o_waddr  out  ADDR_WIDTH  text buffer write address.
- o_wdata  out  8  text buffer write data.

## Operation
- States: IDLE, WRITE, CLEAR.
- clear_pending flag: set when i_clear=1 in any cycle while the block is not in CLEAR. Cleared on entry to CLEAR. i_clear asserted during CLEAR is ignored (merged into the running clear).
- IDLE, with clear_pending or i_clear set: go to CLEAR. Clear has priority over both requesters.
- IDLE, otherwise:
  - Only one requester asserting req: grant it.
  - Both asserting: grant the one that was not granted last (rr_last).
  - On a grant: register addr and char onto o_waddr and o_wdata, set o_we=1 and the granted requester's ack to 1, update rr_last, go to WRITE.
- WRITE: o_we and ack drop to 0; go to IDLE. Requests are not sampled in WRITE.
- CLEAR: o_we=1, o_wdata=FILL_CHAR, o_waddr counts 0..CHAR_COUNT-1, one cell per cycle.
  - After address CHAR_COUNT-1 is issued: o_clear_done=1 for one cycle, go to IDLE.
  - Requests stay pending (no ack) throughout CLEAR.
- Address width: the clear counter is ADDR_WIDTH+1 bits. It never wraps past CHAR_COUNT-1. Requester addresses ≥ CHAR_COUNT are passed through unchanged; the buffer ignores them.
- o_busy = clear_pending | (state==CLEAR).
- Requester contract:
  - addr and char must be stable from req assertion through the ack cycle.
  - Deassert req on the cycle after ack, or keep it high to request another write.

## Timing
- All outputs are registered.
- Reset values: o_we=0, o_waddr=0, o_wdata=0, o_a_ack=0, o_b_ack=0, o_clear_done=0, o_busy=0. State=IDLE, clear_pending=0, rr_last=B (so A wins the first tie).
- Write latency: req sampled in IDLE at edge N; o_we and ack are high in cycle N+1. Peak throughput is one write per 2 cycles. Two contending requesters are each served every 4 cycles.
- Clear: entry 1 cycle after IDLE samples clear. Then CHAR_COUNT consecutive cycles of o_we=1. o_clear_done coincides with the cycle after the last fill write. Total CHAR_COUNT+2 cycles from i_clear to done.
- i_clear in the same cycle as a request in IDLE: clear wins; the request is served after the clear.
- i_clear during WRITE: latched; CLEAR starts after the following IDLE cycle.
- Reset asserted mid-write or mid-clear: all outputs return to their reset values on the next edge. A partial clear is abandoned and not resumed.

## Structure
- Shared include lcd_text_defs.vh: state encodings (IDLE, WRITE, CLEAR), default CHAR_COUNT, ADDR_WIDTH and FILL_CHAR, shared with the text engine.
- One sub-module is natural: rr_arbiter2, a two-way round-robin grant with a priority bit. It contains only the combinational grant logic plus rr_last.
- FSM, clear counter and output registers stay in text_write_arbiter.

## Test plan
- Reset, then A writes addr 5, char 0x41: o_we=1, o_waddr=5, o_wdata=0x41, o_a_ack=1 in the cycle after the request; nothing in the cycle after that.
- A and B held high continuously: grants alternate A,B,A,B. Each ack is 4 cycles apart; the first grant goes to A.
- i_clear pulse: 64 consecutive writes of 0x20 to addresses 0..63, then o_clear_done for 1 cycle. o_busy is high from the cycle after i_clear until done.
- B request raised at clear address 10: no o_b_ack until clear_done. B's write issues within 2 cycles after done.
- i_clear pulsed again at clear address 30: exactly 64 fill writes total and one done pulse.
- i_rst asserted at clear address 20: all outputs 0 next cycle. A subsequent A request is served normally and no clear resumes.

Source files
------------

// File: rtl/text_write_arbiter_pkg.sv
// Shared constants and types for the text buffer write arbiter.
package text_write_arbiter_pkg;

  localparam int unsigned CHAR_COUNT = 64;
  localparam int unsigned ADDR_WIDTH = 6;
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam logic [7:0]  FILL_CHAR  = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            data;
  } wr_t;

endpackage

// File: rtl/text_write_arbiter_if.sv
// Requester, clear and text-buffer write signals of the arbiter.
interface text_write_arbiter_if;
  import text_write_arbiter_pkg::*;

  logic                  i_a_req;
  logic [ADDR_WIDTH-1:0] i_a_addr;
  logic [7:0]            i_a_char;
  logic                  o_a_ack;
  logic                  i_b_req;
  logic [ADDR_WIDTH-1:0] i_b_addr;
  logic [7:0]            i_b_char;
  logic                  o_b_ack;
  logic                  i_clear;
  logic                  o_clear_done;
  logic                  o_busy;
  logic                  o_we;
  logic [ADDR_WIDTH-1:0] o_waddr;
  logic [7:0]            o_wdata;

  modport master (
    output i_a_req, i_a_addr, i_a_char, i_b_req, i_b_addr, i_b_char, i_clear,
    input  o_a_ack, o_b_ack, o_clear_done, o_busy, o_we, o_waddr, o_wdata
  );

  modport slave (
    input  i_a_req, i_a_addr, i_a_char, i_b_req, i_b_addr, i_b_char, i_clear,
    output o_a_ack, o_b_ack, o_clear_done, o_busy, o_we, o_waddr, o_wdata
  );

endinterface

// File: rtl/text_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the requester not served last wins a tie.
module text_write_arbiter_rr_arbiter2
  import text_write_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic take_i,
  output logic gnt_a_c,
  output logic gnt_b_c
);

  rr_e rr_last_q;

  always_comb begin
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    if (req_a_i && (!req_b_i || rr_last_q == RR_B)) begin
      gnt_a_c = 1'b1;
    end else if (req_b_i) begin
      gnt_b_c = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_last_q <= RR_B;
    end else if (take_i) begin
      rr_last_q <= gnt_b_c ? RR_B : RR_A;
    end
  end

endmodule

// File: rtl/text_write_arbiter.sv
// Shares the text buffer write port between two requesters and a bulk clear.
module text_write_arbiter
  import text_write_arbiter_pkg::*;
(
  input logic                 i_clk,
  input logic                 i_rst,
  text_write_arbiter_if.slave bus
);

  state_e               state_q;
  logic                 clear_pending_q;
  logic [CNT_WIDTH-1:0] clr_cnt_q;
  wr_t                  wr_q;
  logic                 we_q;
  logic                 a_ack_q;
  logic                 b_ack_q;
  logic                 clear_done_q;
  logic                 busy_q;

  logic gnt_a_c;
  logic gnt_b_c;
  logic clear_req_c;
  logic take_c;
  wr_t  req_wr_c;

  // Clear beats any requester whenever the FSM is free to choose.
  assign clear_req_c = clear_pending_q | bus.i_clear;
  assign take_c      = (state_q == ST_IDLE) && !clear_req_c && (bus.i_a_req || bus.i_b_req);
  assign req_wr_c    = gnt_a_c ? {bus.i_a_addr, bus.i_a_char} : {bus.i_b_addr, bus.i_b_char};

  text_write_arbiter_rr_arbiter2 u_rr_arbiter2 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .req_a_i (bus.i_a_req),
    .req_b_i (bus.i_b_req),
    .take_i  (take_c),
    .gnt_a_c (gnt_a_c),
    .gnt_b_c (gnt_b_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      clear_pending_q <= 1'b0;
      clr_cnt_q       <= '0;
      wr_q            <= '0;
      we_q            <= 1'b0;
      a_ack_q         <= 1'b0;
      b_ack_q         <= 1'b0;
      clear_done_q    <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      we_q         <= 1'b0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      clear_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (clear_req_c) begin
            state_q         <= ST_CLEAR;
            clear_pending_q <= 1'b0;
            clr_cnt_q       <= '0;
            busy_q          <= 1'b1;
          end else begin
            busy_q <= 1'b0;
            if (take_c) begin
              state_q <= ST_WRITE;
              we_q    <= 1'b1;
              a_ack_q <= gnt_a_c;
              b_ack_q <= gnt_b_c;
              wr_q    <= req_wr_c;
            end
          end
        end
        ST_WRITE: begin
          state_q         <= ST_IDLE;
          clear_pending_q <= clear_req_c;
          busy_q          <= clear_req_c;
        end
        ST_CLEAR: begin
          // Counter runs one past the last cell so the done pulse follows the final write.
          if (clr_cnt_q == CNT_WIDTH'(CHAR_COUNT)) begin
            state_q      <= ST_IDLE;
            clear_done_q <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            we_q      <= 1'b1;
            wr_q      <= '{addr: clr_cnt_q[ADDR_WIDTH-1:0], data: FILL_CHAR};
            clr_cnt_q <= clr_cnt_q + CNT_WIDTH'(1);
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= clear_pending_q;
        end
      endcase
    end
  end

  assign bus.o_we         = we_q;
  assign bus.o_waddr      = wr_q.addr;
  assign bus.o_wdata      = wr_q.data;
  assign bus.o_a_ack      = a_ack_q;
  assign bus.o_b_ack      = b_ack_q;
  assign bus.o_clear_done = clear_done_q;
  assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_text_write_arbiter.sv
// Self-checking bench: vector table, multi-cycle corner sequences and a randomized run against a timeline model.
module tb_text_write_arbiter;
  import text_write_arbiter_pkg::*;

  localparam int unsigned OW = 1 + ADDR_WIDTH + 8 + 4;
  typedef logic [OW-1:0] obs_t;

  typedef struct {
    bit                    rst;
    bit                    clr;
    bit                    ar;
    logic [ADDR_WIDTH-1:0] aa;
    logic [7:0]            ac;
    bit                    br;
    logic [ADDR_WIDTH-1:0] ba;
    logic [7:0]            bc;
    obs_t                  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  text_write_arbiter_if bus ();

  text_write_arbiter dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  function automatic obs_t pack(bit we, int wa, int wd, bit aak, bit bak, bit dn, bit bz);
    return {we, ADDR_WIDTH'(wa), 8'(wd), aak, bak, dn, bz};
  endfunction

  function automatic obs_t observe();
    return {bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_a_ack, bus.o_b_ack,
            bus.o_clear_done, bus.o_busy};
  endfunction

  function automatic vec_t mv(bit r, bit c, bit ar, int aa, int ac, bit br, int ba, int bc,
                              bit we, int wa, int wd, bit aak, bit bak, bit bz);
    vec_t v;
    v.rst = r;  v.clr = c;
    v.ar  = ar; v.aa  = ADDR_WIDTH'(aa); v.ac = 8'(ac);
    v.br  = br; v.ba  = ADDR_WIDTH'(ba); v.bc = 8'(bc);
    v.exp = pack(we, wa, wd, aak, bak, 1'b0, bz);
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s #%0d got=%h want=%h (we,waddr,wdata,a_ack,b_ack,done,busy)",
               nm, idx, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit c, input bit ar, input logic [ADDR_WIDTH-1:0] aa,
                       input logic [7:0] ac, input bit br, input logic [ADDR_WIDTH-1:0] ba,
                       input logic [7:0] bc);
    rst          = r;
    bus.i_clear  = c;
    bus.i_a_req  = ar;
    bus.i_a_addr = aa;
    bus.i_a_char = ac;
    bus.i_b_req  = br;
    bus.i_b_addr = ba;
    bus.i_b_char = bc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    check(nm, 0, observe(), '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Timeline model: a clear sampled at cycle cs fills during cs+2..cs+65 and reports done
  // at cs+66; a grant sampled at cycle c blocks sampling until c+2.
  int                    m_cyc = 0;
  int                    m_idle_at = 0;
  int                    m_cs = -1000;
  bit                    m_pend = 1'b0;
  bit                    m_last_b = 1'b1;
  logic [ADDR_WIDTH-1:0] m_wa = '0;
  logic [7:0]            m_wd = '0;
  obs_t                  m_exp = '0;

  task automatic model_step(input bit r, input bit c, input bit ar, input logic [ADDR_WIDTH-1:0] aa,
                            input logic [7:0] ac, input bit br, input logic [ADDR_WIDTH-1:0] ba,
                            input logic [7:0] bc);
    bit we, aak, bak, dn, bz, in_clr, pick_a;
    int k;
    we = 1'b0; aak = 1'b0; bak = 1'b0; dn = 1'b0;
    if (r) begin
      m_cyc++;
      m_idle_at = m_cyc;
      m_cs      = -1000;
      m_pend    = 1'b0;
      m_last_b  = 1'b1;
      m_wa      = '0;
      m_wd      = '0;
      m_exp     = '0;
      return;
    end
    in_clr = (m_cyc > m_cs) && (m_cyc <= m_cs + int'(CHAR_COUNT) + 1);
    if (!in_clr && c) m_pend = 1'b1;
    if (m_cyc >= m_idle_at) begin
      if (m_pend) begin
        m_cs      = m_cyc;
        m_pend    = 1'b0;
        m_idle_at = m_cyc + int'(CHAR_COUNT) + 2;
      end else if (ar || br) begin
        pick_a    = ar && (!br || m_last_b);
        we        = 1'b1;
        aak       = pick_a;
        bak       = !pick_a;
        m_wa      = pick_a ? aa : ba;
        m_wd      = pick_a ? ac : bc;
        m_last_b  = !pick_a;
        m_idle_at = m_cyc + 2;
      end
    end else if (in_clr) begin
      k = m_cyc - m_cs - 1;
      if (k < int'(CHAR_COUNT)) begin
        we   = 1'b1;
        m_wa = ADDR_WIDTH'(k);
        m_wd = FILL_CHAR;
      end else begin
        dn = 1'b1;
      end
    end
    m_cyc++;
    bz    = m_pend || ((m_cyc > m_cs) && (m_cyc <= m_cs + int'(CHAR_COUNT) + 1));
    m_exp = {we, m_wa, m_wd, aak, bak, dn, bz};
  endtask

  initial begin
    vec_t                  vecs[19];
    obs_t                  o;
    int                    fills, bad, dones, early_b, busy_low, done_at, got, we_cnt;
    bit                    b_on, a_act, b_act, r, c;
    logic [ADDR_WIDTH-1:0] a_ad, b_ad;
    logic [7:0]            a_ch, b_ch;

    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);

    //            rst clr ar aa  ac    br ba  bc     we wa  wd    aak bak bz
    vecs[0]  = mv(1, 0, 0, 0, 0,    0, 0, 0,     0, 0,  0,    0, 0, 0);
    vecs[1]  = mv(0, 0, 1, 5, 'h41, 0, 0, 0,     1, 5,  'h41, 1, 0, 0);
    vecs[2]  = mv(0, 0, 0, 0, 0,    0, 0, 0,     0, 5,  'h41, 0, 0, 0);
    vecs[3]  = mv(0, 0, 0, 0, 0,    1, 9, 'h42,  1, 9,  'h42, 0, 1, 0);
    vecs[4]  = mv(0, 0, 0, 0, 0,    0, 9, 'h42,  0, 9,  'h42, 0, 0, 0);
    vecs[5]  = mv(0, 0, 1, 1, 'h61, 1, 2, 'h62,  1, 1,  'h61, 1, 0, 0);
    vecs[6]  = mv(0, 0, 1, 1, 'h61, 1, 2, 'h62,  0, 1,  'h61, 0, 0, 0);
    vecs[7]  = mv(0, 0, 1, 1, 'h61, 1, 2, 'h62,  1, 2,  'h62, 0, 1, 0);
    vecs[8]  = mv(0, 0, 1, 1, 'h61, 1, 2, 'h62,  0, 2,  'h62, 0, 0, 0);
    vecs[9]  = mv(0, 0, 1, 1, 'h61, 1, 2, 'h62,  1, 1,  'h61, 1, 0, 0);
    vecs[10] = mv(0, 1, 0, 1, 'h61, 1, 2, 'h62,  0, 1,  'h61, 0, 0, 1);
    vecs[11] = mv(0, 0, 0, 0, 0,    1, 2, 'h62,  0, 1,  'h61, 0, 0, 1);
    vecs[12] = mv(0, 0, 0, 0, 0,    1, 2, 'h62,  1, 0,  'h20, 0, 0, 1);
    vecs[13] = mv(0, 0, 0, 0, 0,    1, 2, 'h62,  1, 1,  'h20, 0, 0, 1);
    vecs[14] = mv(1, 0, 0, 0, 0,    1, 2, 'h62,  0, 0,  0,    0, 0, 0);
    vecs[15] = mv(0, 0, 0, 0, 0,    1, 2, 'h62,  1, 2,  'h62, 0, 1, 0);
    vecs[16] = mv(0, 0, 0, 0, 0,    0, 0, 0,     0, 2,  'h62, 0, 0, 0);
    vecs[17] = mv(0, 1, 1, 7, 'h77, 0, 0, 0,     0, 2,  'h62, 0, 0, 1);
    vecs[18] = mv(0, 0, 1, 7, 'h77, 0, 0, 0,     1, 0,  'h20, 0, 0, 1);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].ar, vecs[i].aa, vecs[i].ac,
            vecs[i].br, vecs[i].ba, vecs[i].bc);
      tick();
      check("vec", i, observe(), vecs[i].exp);
    end

    // Both requesters held: A first, then strict alternation every 2 cycles.
    do_reset("contend_reset");
    drive(1'b0, 1'b0, 1'b1, ADDR_WIDTH'(3), 8'h33, 1'b1, ADDR_WIDTH'(4), 8'h34);
    for (int k = 1; k <= 16; k++) begin
      tick();
      case (k % 4)
        1:       check("contend", k, observe(), pack(1, 3, 'h33, 1, 0, 0, 0));
        2:       check("contend", k, observe(), pack(0, 3, 'h33, 0, 0, 0, 0));
        3:       check("contend", k, observe(), pack(1, 4, 'h34, 0, 1, 0, 0));
        default: check("contend", k, observe(), pack(0, 4, 'h34, 0, 0, 0, 0));
      endcase
    end

    // Clear with B raised at fill 10 and a second clear pulse at fill 30.
    do_reset("clr_reset");
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    check("clr_entry", 1, observe(), pack(0, 0, 0, 0, 0, 0, 1));
    bus.i_clear = 1'b0;
    fills = 0; bad = 0; dones = 0; early_b = 0; busy_low = 0; done_at = -1; b_on = 1'b0;
    for (int n = 2; n <= 90 && done_at < 0; n++) begin
      tick();
      if (bus.o_b_ack) begin
        early_b++;
      end else if (bus.o_we) begin
        if (bus.o_waddr != ADDR_WIDTH'(fills) || bus.o_wdata != FILL_CHAR || n != fills + 2) bad++;
        fills++;
      end
      if (bus.o_clear_done) begin
        dones++;
        done_at = n;
      end else if (!bus.o_busy) begin
        busy_low++;
      end
      if (bus.o_we && bus.o_waddr == ADDR_WIDTH'(10) && !b_on) begin
        b_on         = 1'b1;
        bus.i_b_req  = 1'b1;
        bus.i_b_addr = ADDR_WIDTH'(33);
        bus.i_b_char = 8'h55;
      end
      bus.i_clear = bus.o_we && bus.o_waddr == ADDR_WIDTH'(30);
    end
    bus.i_clear = 1'b0;
    check_int("clr_fills", fills, 64);
    check_int("clr_order_errs", bad, 0);
    check_int("clr_done_cycle", done_at, 66);
    check_int("clr_busy_gaps", busy_low, 0);
    check_int("clr_early_b_ack", early_b, 0);
    got = 0;
    for (int k = 0; k < 2 && got == 0; k++) begin
      tick();
      if (bus.o_b_ack && bus.o_we && bus.o_waddr == ADDR_WIDTH'(33) && bus.o_wdata == 8'h55) got = 1;
    end
    check_int("clr_b_served", got, 1);
    bus.i_b_req = 1'b0;
    check_int("clr_busy_after", int'(bus.o_busy), 0);
    we_cnt = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (bus.o_clear_done) dones++;
      if (bus.o_we) we_cnt++;
    end
    check_int("clr_single_done", dones, 1);
    check_int("clr_no_refill", we_cnt, 0);

    // Reset in the middle of a clear abandons it for good.
    do_reset("rst_reset");
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    bus.i_clear = 1'b0;
    got = 0;
    for (int k = 0; k < 80 && got == 0; k++) begin
      tick();
      if (bus.o_we && bus.o_waddr == ADDR_WIDTH'(20)) got = 1;
    end
    check_int("rst_reach_20", got, 1);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    check("rst_mid_clear", 0, observe(), '0);
    drive(1'b0, 1'b0, 1'b1, ADDR_WIDTH'(7), 8'h37, 1'b0, '0, '0);
    tick();
    check("rst_then_a", 0, observe(), pack(1, 7, 'h37, 1, 0, 0, 0));
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    we_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (bus.o_we || bus.o_clear_done) we_cnt++;
    end
    check_int("rst_no_resume", we_cnt, 0);

    // Randomized protocol-compliant requesters, clears and resets against the model.
    a_act = 1'b0; b_act = 1'b0;
    a_ad = '0; a_ch = '0; b_ad = '0; b_ch = '0;
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    model_step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    check("rand_reset", 0, observe(), m_exp);
    for (int i = 0; i < 3000; i++) begin
      if (!a_act && $urandom_range(0, 2) == 0) begin
        a_act = 1'b1; a_ad = ADDR_WIDTH'($urandom); a_ch = 8'($urandom);
      end
      if (!b_act && $urandom_range(0, 2) == 0) begin
        b_act = 1'b1; b_ad = ADDR_WIDTH'($urandom); b_ch = 8'($urandom);
      end
      r = ($urandom_range(0, 799) == 0);
      c = ($urandom_range(0, 119) == 0);
      drive(r, c, a_act, a_ad, a_ch, b_act, b_ad, b_ch);
      model_step(r, c, a_act, a_ad, a_ch, b_act, b_ad, b_ch);
      tick();
      check("rand", i, observe(), m_exp);
      if (m_exp[3]) begin
        if ($urandom_range(0, 1) == 1) begin
          a_ad = ADDR_WIDTH'($urandom); a_ch = 8'($urandom);
        end else begin
          a_act = 1'b0;
        end
      end
      if (m_exp[2]) begin
        if ($urandom_range(0, 1) == 1) begin
          b_ad = ADDR_WIDTH'($urandom); b_ch = 8'($urandom);
        end else begin
          b_act = 1'b0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
